fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard controller for the pipelined MIPS32 core, sitting beside the ID/EX–EX boundary. It keeps a shadow pipeline of in-flight register writes `FWD_DEPTH` stages deep. For each of `NSRC` source operands of the instruction currently in EX, it selects the youngest matching producer stage. It raises a stall when the youngest producer is a load whose data is not yet available, and it counts stall cycles for performance monitoring.

---
 rtl/fwd_hazard_unit_if.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 66 ++++++
 tb/tb_fwd_hazard_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - EX-stage operand/hazard bundle for fwd_hazard_unit
interface fwd_hazard_unit_if #(
  parameter int NSRC      = 2,
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int CNT_W     = 16,
  parameter int SELW      = $clog2(FWD_DEPTH + 1)
);
  logic                   ex_valid;
  logic [REG_AW-1:0]      ex_rd;
  logic                   ex_we;
  logic                   ex_load;
  logic [NSRC*REG_AW-1:0] ex_src;
  logic [NSRC-1:0]        ex_src_used;
  logic                   flush;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   stall;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output ex_valid, ex_rd, ex_we, ex_load, ex_src, ex_src_used, flush,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_rd, ex_we, ex_load, ex_src, ex_src_used, flush,
    output fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and load-use stall for the EX stage
module fwd_hazard_unit #(
  parameter int NSRC      = 2,
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  parameter int SELW      = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  fwd_hazard_unit_if.slave bus
);

  logic [FWD_DEPTH:1] r_valid;
  logic [FWD_DEPTH:1] r_we;
  logic [FWD_DEPTH:1] r_load;
  logic [REG_AW-1:0]  r_rd [1:FWD_DEPTH];
  logic [CNT_W-1:0]   r_stall_cnt;

  logic [NSRC*SELW-1:0] w_sel;
  logic [NSRC-1:0]      w_haz;
  logic                 w_stall;

  // Scan oldest to youngest so the youngest matching stage is the last write.
  always_comb begin
    w_sel = '0;
    w_haz = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (r_valid[k] && r_we[k] && (r_rd[k] != '0) &&
            (r_rd[k] == bus.ex_src[i*REG_AW +: REG_AW]) && bus.ex_src_used[i]) begin
          w_sel[i*SELW +: SELW] = SELW'(k);
          w_haz[i]              = r_load[k] && (k <= LOAD_LAT);
        end
      end
    end
  end

  assign w_stall       = !rst && bus.ex_valid && !bus.flush && (|w_haz);
  assign bus.stall     = w_stall;
  assign bus.fwd_sel   = rst ? '0 : w_sel;
  assign bus.stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_we[k]    <= r_we[k-1];
        r_load[k]  <= r_load[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      // A stalled or flushed EX instruction leaves a bubble behind it.
      r_valid[1] <= bus.ex_valid && !bus.flush && !w_stall;
      r_we[1]    <= bus.ex_we;
      r_load[1]  <= bus.ex_load;
      r_rd[1]    <= bus.ex_rd;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed table-driven bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.CNT_W(16)) bus0 ();
  fwd_hazard_unit_if #(.CNT_W(2))  bus1 ();

  fwd_hazard_unit #(.CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  fwd_hazard_unit #(.CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct {
    int r, v, rd, we, ld, s0, s1, used, fl;
    int e_sel0, e_sel1, e_stall, e_cnt;
  } vec_t;

  vec_t tbl [20];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(int r, int v, int rd, int we, int ld, int s0, int s1,
                              int used, int fl, int e_sel0, int e_sel1, int e_stall,
                              int e_cnt);
    vec_t t;
    t.r = r; t.v = v; t.rd = rd; t.we = we; t.ld = ld; t.s0 = s0; t.s1 = s1;
    t.used = used; t.fl = fl; t.e_sel0 = e_sel0; t.e_sel1 = e_sel1;
    t.e_stall = e_stall; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic drive(vec_t t);
    rst              = t.r[0];
    bus0.ex_valid    = t.v[0];    bus1.ex_valid    = t.v[0];
    bus0.ex_rd       = t.rd[4:0]; bus1.ex_rd       = t.rd[4:0];
    bus0.ex_we       = t.we[0];   bus1.ex_we       = t.we[0];
    bus0.ex_load     = t.ld[0];   bus1.ex_load     = t.ld[0];
    bus0.ex_src      = {t.s1[4:0], t.s0[4:0]};
    bus1.ex_src      = {t.s1[4:0], t.s0[4:0]};
    bus0.ex_src_used = t.used[1:0]; bus1.ex_src_used = t.used[1:0];
    bus0.flush       = t.fl[0];   bus1.flush       = t.fl[0];
  endtask

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare mid-cycle, then advance just past the next rising edge.
  task automatic apply(vec_t t, string tag);
    drive(t);
    @(negedge clk);
    chk({tag, " stall"}, int'(bus0.stall), t.e_stall);
    if (t.e_stall == 0) begin
      chk({tag, " sel0"}, int'(bus0.fwd_sel[1:0]), t.e_sel0);
      chk({tag, " sel1"}, int'(bus0.fwd_sel[3:2]), t.e_sel1);
    end
    if (t.e_cnt >= 0) chk({tag, " cnt"}, int'(bus0.stall_cnt), t.e_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               r v rd we ld s0 s1 us fl  sel0 sel1 stl cnt
    tbl[0]  = mk(1, 1, 5, 1, 0, 5, 5, 3, 0,   0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 5, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 6, 0, 0, 5, 0, 1, 0,   1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 10, 1, 0, 5, 6, 3, 0,  2, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 1, 0, 5, 10, 3, 0,  0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 3, 1, 0, 0, 10, 3, 0,  0, 2, 0, 0);
    tbl[6]  = mk(0, 1, 3, 1, 0, 3, 3, 2, 0,   0, 1, 0, 0);
    tbl[7]  = mk(0, 1, 7, 1, 1, 3, 3, 2, 0,   0, 1, 0, 0);
    tbl[8]  = mk(0, 1, 8, 1, 0, 7, 0, 1, 0,   0, 0, 1, 0);
    tbl[9]  = mk(0, 1, 8, 1, 0, 7, 0, 1, 0,   2, 0, 0, 1);
    tbl[10] = mk(0, 1, 7, 1, 1, 8, 0, 1, 0,   1, 0, 0, 1);
    tbl[11] = mk(0, 1, 9, 1, 1, 7, 8, 2, 0,   0, 2, 0, 1);
    tbl[12] = mk(0, 1, 7, 1, 1, 7, 0, 1, 0,   2, 0, 0, 1);
    tbl[13] = mk(0, 1, 11, 1, 0, 7, 9, 3, 1,  1, 2, 0, 1);
    tbl[14] = mk(0, 1, 11, 1, 0, 7, 0, 1, 0,  2, 0, 0, 1);
    tbl[15] = mk(0, 1, 12, 1, 1, 11, 0, 1, 0, 1, 0, 0, 1);
    tbl[16] = mk(0, 1, 13, 1, 0, 12, 12, 3, 0, 0, 0, 1, 1);
    tbl[17] = mk(0, 1, 13, 1, 0, 12, 12, 3, 0, 2, 2, 0, 2);
    tbl[18] = mk(0, 0, 13, 1, 0, 13, 0, 1, 0, 1, 0, 0, 2);
    tbl[19] = mk(0, 0, 13, 1, 0, 13, 0, 1, 0, 2, 0, 0, 2);

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-operation: a live producer must not survive reset.
    apply(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2), "rst_pre");
    apply(mk(0, 1, 4, 1, 0, 9, 0, 1, 0, 1, 0, 0, 2), "rst_fwd");
    drive(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1));
    @(posedge clk);
    #1;
    apply(mk(1, 1, 9, 1, 1, 9, 9, 3, 0, 0, 0, 0, -1), "rst_hold");
    apply(mk(0, 1, 1, 1, 0, 9, 0, 1, 0, 0, 0, 0, 0), "rst_post");
    chk("rst_post cnt1", int'(bus1.stall_cnt), 0);

    // Counter saturation: repeated load-use pairs.
    for (int i = 0; i < 6; i++) begin
      apply(mk(0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, i), $sformatf("sat_ld%0d", i));
      drive(mk(0, 1, 1, 1, 0, 7, 0, 1, 0, 0, 0, 1, -1));
      @(negedge clk);
      chk($sformatf("sat_stall%0d", i), int'(bus1.stall), 1);
      @(posedge clk);
      #1;
      chk($sformatf("sat_cnt2b_%0d", i), int'(bus1.stall_cnt), (i + 1 > 3) ? 3 : i + 1);
      chk($sformatf("sat_cnt16b_%0d", i), int'(bus0.stall_cnt), i + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
